reservation_station: RTL and testbench
======================================

// Module: reservation_station
// PURPOSE
//  ALU reservation station: holds dispatched ALU ops until both operands are known, snoops ALU and LSB
//  result broadcasts for wakeup, and issues one ready op per cycle to the ALU as registered operands.
//  Sits between the dispatcher (upstream) and the alu (downstream).
// PARAMETERS
//  RS_SIZE_WIDTH    3  log2 of entry count (RS_SIZE = 8)
//  ROB_SIZE_WIDTH   3  ROB tag width (= `ROB_SIZE_WIDTH)
//  OP_L1_WIDTH      4  ALU L1 opcode width (= `CALC_OP_L1_NUM_WIDTH)
// PORTS
//  clk_in          in   1   clock; all state updates on posedge
//  rst_in          in   1   synchronous reset, active-low (0 = reset)
//  rdy_in          in   1   global enable; 0 = hold all state and outputs
//  need_flush_in   in   1   misprediction flush; clears all entries
//  inst_valid_in   in   1   dispatch request this cycle
//  vj_in, vk_in    in   32  operand values (meaningful only when matching has_* is 0)
//  has_qj_in       in   1   1 = opr1 pending on ROB tag qj_in
//  has_qk_in       in   1   1 = opr2 pending on ROB tag qk_in
//  qj_in, qk_in    in   ROB_SIZE_WIDTH  producer tags
//  rob_id_in       in   ROB_SIZE_WIDTH  destination ROB tag of dispatched op
//  op_L1_in        in   OP_L1_WIDTH     ALU L1 opcode
//  op_L2_in        in   1   ALU L2 select (SUB/SRA)
//  full_out        out  1   all entries busy (combinational from busy bits)
//  alu_ready_in    in   1   ALU broadcast valid (alu ready_out)
//  alu_value_in    in   32  ALU result; alu_dep_in in ROB_SIZE_WIDTH its tag
//  lsb_ready_in    in   1   LSB broadcast valid; lsb_value_in 32, lsb_dep_in ROB_SIZE_WIDTH
//  valid_out       out  1   issue to ALU this cycle (alu valid_in)
//  opr1_out, opr2_out out 32 issued operands
//  dependency_out  out  ROB_SIZE_WIDTH  issued ROB tag
//  op_L1_out       out  OP_L1_WIDTH; op_L2_out out 1  issued opcode
// BEHAVIOUR
//  - Entry fields: busy, vj, vk, has_qj, has_qk, qj, qk, rob_id, op_L1, op_L2.
//  - Reset (rst_in=0 at posedge): all busy=0; valid_out=0, opr*/dependency_out/op_*=0; full_out=0.
//  - rst_in has priority over rdy_in; rdy_in=0 freezes everything (valid_out held).
//  - Flush (need_flush_in=1, rdy_in=1): all busy<=0, valid_out<=0; dispatch and issue that cycle dropped.
//  - Dispatch: if inst_valid_in && !full_out, write lowest-index free entry. If inst_valid_in while
//    full_out=1, request ignored, no state change.
//  - Wakeup: for every busy entry and every valid bus (ALU, LSB): has_qj && qj==dep -> vj<=value,
//    has_qj<=0 (same for k). Both operands and both buses may hit in one cycle.
//  - Dispatch bypass: incoming has_qj_in && qj_in matches a valid broadcast same cycle -> store value,
//    has_qj<=0 (same for k). No op may be stranded waiting on an already-broadcast tag.
//  - Issue select: lowest-index entry with busy && !has_qj && !has_qk, evaluated on registered state
//    (wakeups/dispatches this cycle not visible until next cycle). Selected entry busy<=0; outputs
//    register its fields, valid_out<=1. No candidate -> valid_out<=0 (data outputs may hold).
//  - Latency: ready entry at dispatch -> valid_out high the cycle after the dispatch edge. Entry woken
//    at edge E -> earliest valid_out after edge E+1. Max one issue per cycle.
//  - A freed slot is reusable by a dispatch in the following cycle (full_out from current busy bits).
//  - ALU result loops back on alu_* buses, so back-to-back dependents issue every other cycle.
// TESTING
//  1. rst_in=0 two cycles, rst_in=1 -> valid_out=0, full_out=0; no issue with no dispatch.
//  2. Dispatch ADD vj=5 vk=7 no deps rob_id=2 -> next cycle valid_out=1, opr1=5, opr2=7,
//     dependency_out=2, op_L1_out=0000; following cycle valid_out=0.
//  3. Dispatch SUB has_qj=1 qj=3 vk=1; 2 cycles later alu_ready_in=1 dep=3 value=0x10 ->
//     issue one cycle after wakeup with opr1=0x10, opr2=1, op_L2_out=1.
//  4. Dispatch has_qk=1 qk=4 while lsb_ready_in=1 lsb_dep=4 value=0xFF -> issues next cycle
//     with opr2=0xFF (bypass); without bypass it would hang.
//  5. Dispatch 8 ops waiting on tag 6 -> full_out=1; 9th dispatch ignored; broadcast tag 6 ->
//     entries issue in index order 0..7 on 8 consecutive cycles, full_out=0 after first issue.
//  6. 3 waiting entries, need_flush_in=1 one cycle, then broadcast their tags -> valid_out stays 0,
//     full_out=0; rdy_in=0 mid-issue holds valid_out and operands unchanged.

Source files
------------

// File: rtl/reservation_station.sv
// ALU reservation station: buffers dispatched ops, wakes them from ALU/LSB broadcasts and issues the
// lowest ready entry one cycle after it becomes ready; dispatch is refused while full_out is high.
module reservation_station #(
  parameter int RS_SIZE_WIDTH  = 3,
  parameter int ROB_SIZE_WIDTH = 3,
  parameter int OP_L1_WIDTH    = 4
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic                      need_flush_in,
  input  logic                      inst_valid_in,
  input  logic [31:0]               vj_in,
  input  logic [31:0]               vk_in,
  input  logic                      has_qj_in,
  input  logic                      has_qk_in,
  input  logic [ROB_SIZE_WIDTH-1:0] qj_in,
  input  logic [ROB_SIZE_WIDTH-1:0] qk_in,
  input  logic [ROB_SIZE_WIDTH-1:0] rob_id_in,
  input  logic [OP_L1_WIDTH-1:0]    op_L1_in,
  input  logic                      op_L2_in,
  output logic                      full_out,
  input  logic                      alu_ready_in,
  input  logic [31:0]               alu_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0] alu_dep_in,
  input  logic                      lsb_ready_in,
  input  logic [31:0]               lsb_value_in,
  input  logic [ROB_SIZE_WIDTH-1:0] lsb_dep_in,
  output logic                      valid_out,
  output logic [31:0]               opr1_out,
  output logic [31:0]               opr2_out,
  output logic [ROB_SIZE_WIDTH-1:0] dependency_out,
  output logic [OP_L1_WIDTH-1:0]    op_L1_out,
  output logic                      op_L2_out
);

  localparam int RS_SIZE = 1 << RS_SIZE_WIDTH;

  typedef struct packed {
    logic [31:0]               vj;
    logic [31:0]               vk;
    logic                      has_qj;
    logic                      has_qk;
    logic [ROB_SIZE_WIDTH-1:0] qj;
    logic [ROB_SIZE_WIDTH-1:0] qk;
    logic [ROB_SIZE_WIDTH-1:0] rob_id;
    logic [OP_L1_WIDTH-1:0]    op_l1;
    logic                      op_l2;
  } entry_t;

  entry_t                   ent [RS_SIZE];
  logic [RS_SIZE-1:0]       busy;
  logic                     free_found;
  logic [RS_SIZE_WIDTH-1:0] free_idx;
  logic                     iss_found;
  logic [RS_SIZE_WIDTH-1:0] iss_idx;
  entry_t                   new_ent;

  assign full_out = &busy;

  // Priority encoders: lowest free slot for dispatch, lowest ready slot for issue.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    iss_found  = 1'b0;
    iss_idx    = '0;
    for (int i = 0; i < RS_SIZE; i++) begin
      if (!busy[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = RS_SIZE_WIDTH'(i);
      end
      if (busy[i] && !ent[i].has_qj && !ent[i].has_qk && !iss_found) begin
        iss_found = 1'b1;
        iss_idx   = RS_SIZE_WIDTH'(i);
      end
    end
  end

  // Incoming op captures a result broadcast in the same cycle so it never waits on a past tag.
  always_comb begin
    new_ent        = '0;
    new_ent.vj     = vj_in;
    new_ent.vk     = vk_in;
    new_ent.has_qj = has_qj_in;
    new_ent.has_qk = has_qk_in;
    new_ent.qj     = qj_in;
    new_ent.qk     = qk_in;
    new_ent.rob_id = rob_id_in;
    new_ent.op_l1  = op_L1_in;
    new_ent.op_l2  = op_L2_in;
    if (has_qj_in && alu_ready_in && alu_dep_in == qj_in) begin
      new_ent.vj     = alu_value_in;
      new_ent.has_qj = 1'b0;
    end else if (has_qj_in && lsb_ready_in && lsb_dep_in == qj_in) begin
      new_ent.vj     = lsb_value_in;
      new_ent.has_qj = 1'b0;
    end
    if (has_qk_in && alu_ready_in && alu_dep_in == qk_in) begin
      new_ent.vk     = alu_value_in;
      new_ent.has_qk = 1'b0;
    end else if (has_qk_in && lsb_ready_in && lsb_dep_in == qk_in) begin
      new_ent.vk     = lsb_value_in;
      new_ent.has_qk = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      busy           <= '0;
      valid_out      <= 1'b0;
      opr1_out       <= '0;
      opr2_out       <= '0;
      dependency_out <= '0;
      op_L1_out      <= '0;
      op_L2_out      <= 1'b0;
      for (int i = 0; i < RS_SIZE; i++) begin
        ent[i] <= '0;
      end
    end else if (rdy_in) begin
      if (need_flush_in) begin
        busy      <= '0;
        valid_out <= 1'b0;
      end else begin
        for (int i = 0; i < RS_SIZE; i++) begin
          if (busy[i]) begin
            if (ent[i].has_qj && alu_ready_in && ent[i].qj == alu_dep_in) begin
              ent[i].vj     <= alu_value_in;
              ent[i].has_qj <= 1'b0;
            end else if (ent[i].has_qj && lsb_ready_in && ent[i].qj == lsb_dep_in) begin
              ent[i].vj     <= lsb_value_in;
              ent[i].has_qj <= 1'b0;
            end
            if (ent[i].has_qk && alu_ready_in && ent[i].qk == alu_dep_in) begin
              ent[i].vk     <= alu_value_in;
              ent[i].has_qk <= 1'b0;
            end else if (ent[i].has_qk && lsb_ready_in && ent[i].qk == lsb_dep_in) begin
              ent[i].vk     <= lsb_value_in;
              ent[i].has_qk <= 1'b0;
            end
          end
        end

        if (iss_found) begin
          busy[iss_idx]  <= 1'b0;
          valid_out      <= 1'b1;
          opr1_out       <= ent[iss_idx].vj;
          opr2_out       <= ent[iss_idx].vk;
          dependency_out <= ent[iss_idx].rob_id;
          op_L1_out      <= ent[iss_idx].op_l1;
          op_L2_out      <= ent[iss_idx].op_l2;
        end else begin
          valid_out <= 1'b0;
        end

        // Dispatch slot is free, so it never collides with the issuing (busy) slot.
        if (inst_valid_in && !full_out) begin
          busy[free_idx] <= 1'b1;
          ent[free_idx]  <= new_ent;
        end
      end
    end
  end

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station: vector table for single-entry flows, hand sequences for
// the full/flush/stall/reset corner cases.
module tb_reservation_station;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in, need_flush_in, inst_valid_in;
  logic [31:0] vj_in, vk_in;
  logic        has_qj_in, has_qk_in;
  logic [2:0]  qj_in, qk_in, rob_id_in;
  logic [3:0]  op_L1_in;
  logic        op_L2_in;
  logic        full_out;
  logic        alu_ready_in;
  logic [31:0] alu_value_in;
  logic [2:0]  alu_dep_in;
  logic        lsb_ready_in;
  logic [31:0] lsb_value_in;
  logic [2:0]  lsb_dep_in;
  logic        valid_out;
  logic [31:0] opr1_out, opr2_out;
  logic [2:0]  dependency_out;
  logic [3:0]  op_L1_out;
  logic        op_L2_out;

  int checks = 0;
  int errors = 0;

  reservation_station dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .need_flush_in(need_flush_in),
    .inst_valid_in(inst_valid_in), .vj_in(vj_in), .vk_in(vk_in),
    .has_qj_in(has_qj_in), .has_qk_in(has_qk_in), .qj_in(qj_in), .qk_in(qk_in),
    .rob_id_in(rob_id_in), .op_L1_in(op_L1_in), .op_L2_in(op_L2_in), .full_out(full_out),
    .alu_ready_in(alu_ready_in), .alu_value_in(alu_value_in), .alu_dep_in(alu_dep_in),
    .lsb_ready_in(lsb_ready_in), .lsb_value_in(lsb_value_in), .lsb_dep_in(lsb_dep_in),
    .valid_out(valid_out), .opr1_out(opr1_out), .opr2_out(opr2_out),
    .dependency_out(dependency_out), .op_L1_out(op_L1_out), .op_L2_out(op_L2_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        rst, rdy, flush, iv;
    logic [31:0] vj, vk;
    logic        hqj, hqk;
    logic [2:0]  qj, qk, rob;
    logic [3:0]  l1;
    logic        l2;
    logic        alu_v;
    logic [31:0] alu_val;
    logic [2:0]  alu_dep;
    logic        lsb_v;
    logic [31:0] lsb_val;
    logic [2:0]  lsb_dep;
    logic        e_valid, e_full, chk_dat;
    logic [31:0] e_opr1, e_opr2;
    logic [2:0]  e_dep;
    logic [3:0]  e_l1;
    logic        e_l2;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t idle();
    vec_t v;
    v = '{rst: 1'b1, rdy: 1'b1, flush: 1'b0, iv: 1'b0, vj: 32'd0, vk: 32'd0, hqj: 1'b0, hqk: 1'b0,
          qj: 3'd0, qk: 3'd0, rob: 3'd0, l1: 4'd0, l2: 1'b0, alu_v: 1'b0, alu_val: 32'd0,
          alu_dep: 3'd0, lsb_v: 1'b0, lsb_val: 32'd0, lsb_dep: 3'd0, e_valid: 1'b0, e_full: 1'b0,
          chk_dat: 1'b0, e_opr1: 32'd0, e_opr2: 32'd0, e_dep: 3'd0, e_l1: 4'd0, e_l2: 1'b0};
    return v;
  endfunction

  function automatic vec_t expect_issue(vec_t v, logic [31:0] o1, logic [31:0] o2,
                                        logic [2:0] dep, logic [3:0] l1, logic l2);
    vec_t r;
    r = v;
    r.e_valid = 1'b1; r.chk_dat = 1'b1;
    r.e_opr1 = o1; r.e_opr2 = o2; r.e_dep = dep; r.e_l1 = l1; r.e_l2 = l2;
    return r;
  endfunction

  task automatic drive(input vec_t v);
    rst_in = v.rst; rdy_in = v.rdy; need_flush_in = v.flush; inst_valid_in = v.iv;
    vj_in = v.vj; vk_in = v.vk; has_qj_in = v.hqj; has_qk_in = v.hqk;
    qj_in = v.qj; qk_in = v.qk; rob_id_in = v.rob; op_L1_in = v.l1; op_L2_in = v.l2;
    alu_ready_in = v.alu_v; alu_value_in = v.alu_val; alu_dep_in = v.alu_dep;
    lsb_ready_in = v.lsb_v; lsb_value_in = v.lsb_val; lsb_dep_in = v.lsb_dep;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t v);
    chk({tag, " valid_out"}, 32'(valid_out), 32'(v.e_valid));
    chk({tag, " full_out"}, 32'(full_out), 32'(v.e_full));
    if (v.chk_dat) begin
      chk({tag, " opr1_out"}, opr1_out, v.e_opr1);
      chk({tag, " opr2_out"}, opr2_out, v.e_opr2);
      chk({tag, " dependency_out"}, 32'(dependency_out), 32'(v.e_dep));
      chk({tag, " op_L1_out"}, 32'(op_L1_out), 32'(v.e_l1));
      chk({tag, " op_L2_out"}, 32'(op_L2_out), 32'(v.e_l2));
    end
  endtask

  initial begin
    vec_t v;
    vec_t w;

    // Reset: two cycles low, all outputs zero.
    v = idle(); v.rst = 1'b0; v.chk_dat = 1'b1; tbl.push_back(v); tbl.push_back(v);
    tbl.push_back(idle()); tbl.push_back(idle());
    // Ready ADD issues the cycle after dispatch, then valid drops.
    v = idle(); v.iv = 1; v.vj = 5; v.vk = 7; v.rob = 2; tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 5, 7, 2, 4'b0000, 0));
    tbl.push_back(idle());
    // SUB waiting on tag 3, woken by ALU two cycles later.
    v = idle(); v.iv = 1; v.hqj = 1; v.qj = 3; v.vk = 1; v.rob = 5; v.l2 = 1; tbl.push_back(v);
    tbl.push_back(idle());
    v = idle(); v.alu_v = 1; v.alu_dep = 3; v.alu_val = 32'h10; tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 32'h10, 1, 5, 4'b0000, 1));
    tbl.push_back(idle());
    // LSB bypass on opr2 at dispatch.
    v = idle(); v.iv = 1; v.hqk = 1; v.qk = 4; v.vj = 3; v.rob = 1; v.l1 = 4'd7;
    v.lsb_v = 1; v.lsb_dep = 4; v.lsb_val = 32'hFF; tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 3, 32'hFF, 1, 4'd7, 0));
    tbl.push_back(idle());
    // Both operands bypassed from different buses.
    v = idle(); v.iv = 1; v.hqj = 1; v.qj = 6; v.hqk = 1; v.qk = 7; v.rob = 4; v.l1 = 4'd2;
    v.alu_v = 1; v.alu_dep = 6; v.alu_val = 32'hAA; v.lsb_v = 1; v.lsb_dep = 7; v.lsb_val = 32'hBB;
    tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 32'hAA, 32'hBB, 4, 4'd2, 0));
    tbl.push_back(idle());
    // Both operands woken in-station by both buses in one cycle.
    v = idle(); v.iv = 1; v.hqj = 1; v.qj = 1; v.hqk = 1; v.qk = 2; v.rob = 3; v.l1 = 4'd5;
    tbl.push_back(v);
    v = idle(); v.alu_v = 1; v.alu_dep = 1; v.alu_val = 32'h11;
    v.lsb_v = 1; v.lsb_dep = 2; v.lsb_val = 32'h22; tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 32'h11, 32'h22, 3, 4'd5, 0));
    tbl.push_back(idle());
    // A broadcast with the wrong tag must not wake the entry.
    v = idle(); v.iv = 1; v.hqj = 1; v.qj = 5; v.vk = 9; v.rob = 6; v.l1 = 4'd1; tbl.push_back(v);
    v = idle(); v.alu_v = 1; v.alu_dep = 4; v.alu_val = 32'h99; tbl.push_back(v);
    tbl.push_back(idle());
    v = idle(); v.lsb_v = 1; v.lsb_dep = 5; v.lsb_val = 32'h55; tbl.push_back(v);
    tbl.push_back(expect_issue(idle(), 32'h55, 9, 6, 4'd1, 0));
    tbl.push_back(idle());

    drive(idle());
    foreach (tbl[i]) begin
      drive(tbl[i]);
      step();
      chk_vec($sformatf("vec%0d", i), tbl[i]);
    end

    // Fill all 8 entries waiting on tag 6; 9th (ready) dispatch must be dropped.
    for (int i = 0; i < 8; i++) begin
      v = idle(); v.iv = 1; v.hqj = 1; v.qj = 6; v.vk = 100 + i; v.rob = 3'(i); v.l1 = 4'(i);
      drive(v); step();
      chk($sformatf("fill%0d full_out", i), 32'(full_out), 32'(i == 7));
      chk($sformatf("fill%0d valid_out", i), 32'(valid_out), 32'd0);
    end
    v = idle(); v.iv = 1; v.vj = 1; v.vk = 1; v.rob = 7; drive(v); step();
    chk("ninth full_out", 32'(full_out), 32'd1);
    v = idle(); v.alu_v = 1; v.alu_dep = 6; v.alu_val = 32'h60; drive(v); step();
    chk("wake valid_out", 32'(valid_out), 32'd0);
    chk("wake full_out", 32'(full_out), 32'd1);
    drive(idle());
    for (int i = 0; i < 8; i++) begin
      step();
      w = expect_issue(idle(), 32'h60, 100 + i, 3'(i), 4'(i), 0);
      chk_vec($sformatf("drain%0d", i), w);
    end
    step();
    chk("after drain valid_out", 32'(valid_out), 32'd0);

    // Flush three waiting entries (plus a same-cycle dispatch), then broadcast their tags.
    for (int i = 0; i < 3; i++) begin
      v = idle(); v.iv = 1; v.hqj = 1; v.qj = 3'(i + 1); v.rob = 3'(i); drive(v); step();
    end
    v = idle(); v.flush = 1; v.iv = 1; v.vj = 8; v.vk = 8; v.rob = 5; drive(v); step();
    chk("flush valid_out", 32'(valid_out), 32'd0);
    chk("flush full_out", 32'(full_out), 32'd0);
    v = idle(); v.alu_v = 1; v.alu_dep = 1; v.lsb_v = 1; v.lsb_dep = 2; drive(v); step();
    v = idle(); v.alu_v = 1; v.alu_dep = 3; drive(v); step();
    drive(idle());
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post flush%0d valid_out", i), 32'(valid_out), 32'd0);
      chk($sformatf("post flush%0d full_out", i), 32'(full_out), 32'd0);
    end

    // rdy_in low while an issue is on the outputs holds everything.
    v = idle(); v.iv = 1; v.vj = 1; v.vk = 2; v.rob = 1; drive(v); step();
    v = idle(); v.iv = 1; v.vj = 3; v.vk = 4; v.rob = 2; drive(v); step();
    w = expect_issue(idle(), 1, 2, 1, 0, 0);
    chk_vec("stall first", w);
    v = idle(); v.rdy = 0; v.flush = 1; v.iv = 1; v.vj = 9; v.alu_v = 1; drive(v);
    step(); chk_vec("stall hold0", w);
    step(); chk_vec("stall hold1", w);
    drive(idle()); step();
    chk_vec("stall resume", expect_issue(idle(), 3, 4, 2, 0, 0));
    step();
    chk("stall done valid_out", 32'(valid_out), 32'd0);

    // Reset wins over rdy_in low and clears a pending ready entry.
    v = idle(); v.iv = 1; v.vj = 7; v.vk = 7; v.rob = 3; drive(v); step();
    v = idle(); v.rst = 0; v.rdy = 0; drive(v); step();
    v = idle(); v.rst = 0; v.chk_dat = 1;
    chk_vec("rst over rdy", v);
    drive(idle()); step();
    chk("rst cleared valid_out", 32'(valid_out), 32'd0);
    chk("rst cleared full_out", 32'(full_out), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
